// File: rtl/ins_burst_responder.sv
// Instruction-cache burst-read responder: one backend read per word, in-order returns, finish pulse.
// Optional request alignment check enabled by defining INS_BURST_ALIGN_CHK_EN.
module ins_burst_responder #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_WIDTH      = 30,
    parameter int LEN_WIDTH      = 8,
    parameter int ADDR_STEP      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_burst_req,
    input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic [LEN_WIDTH-1:0]      rd_burst_len,
    output logic                      rd_burst_ready,
    output logic                      rd_burst_data_valid,
    output logic [ISA_WIDTH-1:0]      rd_burst_data,
    output logic                      rd_burst_finish,
    output logic                      mem_rd_en,
    output logic [DDR_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                      mem_rd_ready,
    input  logic                      mem_rd_valid,
    input  logic [ISA_WIDTH-1:0]      mem_rd_data,
    output logic                      rd_burst_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      cmd_cnt_q, cmd_cnt_d;
    logic [LEN_WIDTH-1:0]      ret_cnt_q, ret_cnt_d;
    logic [ISA_WIDTH-1:0]      data_q, data_d;
    logic                      vld_q, vld_d;
    logic                      err_q, err_d;
    logic                      misalign;
    logic                      cmd_fire;
    logic                      ret_fire;

`ifdef INS_BURST_ALIGN_CHK_EN
    assign misalign = |rd_burst_addr[2:0];
`else
    assign misalign = 1'b0;
`endif

    assign cmd_fire = (state_q == S_ISSUE) && mem_rd_ready;
    // Returns only count while a burst is open; extras beyond len are dropped.
    assign ret_fire = mem_rd_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                      && (ret_cnt_q != len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cmd_cnt_q <= '0;
            ret_cnt_q <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cmd_cnt_q <= cmd_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cmd_cnt_d = cmd_cnt_q;
        ret_cnt_d = ret_cnt_q;
        err_d     = 1'b0;
        vld_d     = ret_fire;
        data_d    = ret_fire ? mem_rd_data : data_q;
        if (ret_fire) begin
            ret_cnt_d = ret_cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (rd_burst_req) begin
                    if (misalign) begin
                        err_d = 1'b1;
                    end else if (rd_burst_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d    = rd_burst_addr;
                        len_d     = rd_burst_len;
                        cmd_cnt_d = '0;
                        ret_cnt_d = '0;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // addr_q always holds base + cmd_cnt*ADDR_STEP, wrapping naturally.
                if (cmd_fire) begin
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    addr_d    = addr_q + DDR_ADDR_WIDTH'(ADDR_STEP);
                    if (cmd_cnt_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (ret_cnt_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_burst_ready  = (state_q == S_IDLE);
        mem_rd_en       = (state_q == S_ISSUE);
        mem_rd_addr     = (state_q == S_ISSUE) ? addr_q : '0;
        rd_burst_finish = (state_q == S_DONE);
    end

    assign rd_burst_data_valid = vld_q;
    assign rd_burst_data       = data_q;
    assign rd_burst_err        = err_q;

endmodule
